decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter N, default 32, giving the datapath width (legal values 32 or 64).
REQ-002 SHALL have parameter ALU_W, default 4, giving the ALU function code width (matches the existing ALU funct defines).
REQ-003 SHALL have port clk  in  1  as the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  as the reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  to mark upstream instruction valid.
REQ-006 SHALL have port in_ready  out  1  to show the stage can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  in  32  carrying the raw RV instruction.
REQ-008 SHALL have port in_pc  in  N  carrying the PC of in_instr.
REQ-009 SHALL have port controlOverride  in  1  to force the ALU funct to ADD for the captured instruction.
REQ-010 SHALL have port flush  in  1  to discard the held and incoming instruction.
REQ-011 SHALL have port out_valid  out  1  to mark the decoded bundle valid.
REQ-012 SHALL have port out_ready  in  1  to show downstream accepts the bundle.
REQ-013 SHALL have ports out_alu_funct (out, ALU_W), out_rs1/out_rs2/out_rd (out, 5 each), out_immed (out, N), out_pc (out, N) and out_illegal (out, 1), all registered.

Function
REQ-014 SHALL be a one-entry registered stage: in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL capture and decode when in_valid && in_ready && !flush; outputs appear the next cycle (latency 1).
REQ-016 SHALL clear out_valid on a cycle with out_ready=1 and no capture; with out_valid=1 and out_ready=0, SHALL hold all outputs stable.
REQ-017 SHALL, when flush=1, set out_valid=0 next cycle and drop any same-cycle input; flush takes priority over capture.
REQ-018 SHALL decode ALU funct as follows: controlOverride -> ADD; BRANCH with BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU; OP/OP-IMM per funct3, where funct3=000 maps to SUB only for OP with funct7=0100000 (OP-IMM always ADD), funct3=101 maps to SRA when funct7[5]=1 and otherwise SRL; all other opcodes -> ADD; no latch and no undefined value for any encoding.
REQ-019 SHALL produce out_immed sign-extended to N from bit 31 for I, S, B, J and U types (U = {instr[31:12],12'b0}), and for shift-immediates SHALL produce shamt zero-extended: instr[24:20] when N=32, instr[25:20] when N=64.
REQ-020 SHALL produce the immediate type by opcode: LOAD, JALR and OP-IMM -> I; STORE -> S; BRANCH -> B; JAL -> J; LUI and AUIPC -> U; other opcodes -> 0.
REQ-021 SHALL pass rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] and out_pc=in_pc unchanged.

Reset
REQ-022 SHALL, while rst_n=0, immediately force out_valid=0, out_illegal=0, out_alu_funct=ADD code and all other outputs to 0, independent of clk.
REQ-023 SHALL, after release mid-transfer, lose the held bundle and accept new input on the first edge with rst_n=1.

Configuration
REQ-024 SHALL, with macro DECODE_ILLEGAL_EN defined, set out_illegal=1 for any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}, for instr[1:0]!=11, or for OP with funct7 not in {0000000, 0100000}; the bundle is still delivered.
REQ-025 SHALL, without DECODE_ILLEGAL_EN, tie out_illegal to 0 while the port stays present.

Verification
REQ-026 SHALL check: in 0x402081B3 (sub x3,x1,x2) -> next cycle out_alu_funct=SUB, rs1=1, rs2=2, rd=3.
REQ-027 SHALL check: in 0xFFF00093 (addi x1,x0,-1), N=64 -> out_immed=0xFFFFFFFFFFFFFFFF, ALU funct=ADD.
REQ-028 SHALL check: in 0x12345037 (lui x0) -> out_immed=0x12345000; in 0x0080006F (jal) -> out_immed=8.
REQ-029 SHALL check: out_valid=1 with out_ready=0 for 3 cycles while new in_valid is present -> in_ready=0 and outputs are unchanged; then out_ready=1 -> the new instruction appears the next cycle.
REQ-030 SHALL check: flush with in_valid=1 -> out_valid=0 next cycle; rst_n low mid-hold -> out_valid=0 without a clock edge.
REQ-031 SHALL check: in 0x0000000B with DECODE_ILLEGAL_EN -> out_illegal=1; without the macro -> out_illegal=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: one-entry registered RV instruction decode stage (ALU funct, regs, immediate).
// Define DECODE_ILLEGAL_EN to enable illegal-instruction flagging on out_illegal.
module decode_stage #(
    parameter int N     = 32,
    parameter int ALU_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [N-1:0]     in_pc,
    input  logic             controlOverride,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] out_alu_funct,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [N-1:0]     out_immed,
    output logic [N-1:0]     out_pc,
    output logic             out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU function codes are {funct7[5], funct3} of the matching R-type operation.
    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(4'b0011);
    localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4'b0100);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(4'b0101);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4'b0110);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(4'b0111);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(4'b1000);
    localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(4'b1101);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [ALU_W-1:0] alu_d;
    logic [N-1:0]     immed_d;
    logic             capture;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    function automatic logic [N-1:0] sext(input logic [31:0] v);
        return N'($signed(v));
    endfunction

    always_comb begin
        alu_d = ALU_ADD;
        if (!controlOverride) begin
            case (opcode)
                OPC_BRANCH: begin
                    case (funct3)
                        3'b000, 3'b001: alu_d = ALU_SUB;
                        3'b100, 3'b101: alu_d = ALU_SLT;
                        3'b110, 3'b111: alu_d = ALU_SLTU;
                        default:        alu_d = ALU_ADD;
                    endcase
                end
                OPC_OP, OPC_OPIMM: begin
                    case (funct3)
                        3'b000:  alu_d = (opcode == OPC_OP && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_d = ALU_SLL;
                        3'b010:  alu_d = ALU_SLT;
                        3'b011:  alu_d = ALU_SLTU;
                        3'b100:  alu_d = ALU_XOR;
                        3'b101:  alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_d = ALU_OR;
                        default: alu_d = ALU_AND;
                    endcase
                end
                default: alu_d = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        immed_d = '0;
        case (opcode)
            OPC_LOAD, OPC_JALR:
                immed_d = sext({{20{in_instr[31]}}, in_instr[31:20]});
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (N == 64) immed_d = N'(in_instr[25:20]);
                    else         immed_d = N'(in_instr[24:20]);
                end else begin
                    immed_d = sext({{20{in_instr[31]}}, in_instr[31:20]});
                end
            end
            OPC_STORE:
                immed_d = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            OPC_BRANCH:
                immed_d = sext({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0});
            OPC_JAL:
                immed_d = sext({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0});
            OPC_LUI, OPC_AUIPC:
                immed_d = sext({in_instr[31:12], 12'b0});
            default: immed_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_alu_funct <= ALU_ADD;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_immed     <= '0;
            out_pc        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            out_alu_funct <= alu_d;
            out_rs1       <= in_instr[19:15];
            out_rs2       <= in_instr[24:20];
            out_rd        <= in_instr[11:7];
            out_immed     <= immed_d;
            out_pc        <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_d;

    always_comb begin
        illegal_d = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM: illegal_d = 1'b0;
            OPC_OP:  illegal_d = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            default: illegal_d = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) illegal_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_illegal <= 1'b0;
        end else if (!flush && capture) begin
            out_illegal <= illegal_d;
        end
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule
